// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU slice: op encodings, sub-class decode, FSM states.
package alu_pkg;

   typedef logic [3:0] op_t;

   localparam op_t OP_SUB_AB  = 4'b0110;
   localparam op_t OP_SUB_ANB = 4'b0111;
   localparam op_t OP_SUB_AAB = 4'b1011;
   localparam op_t OP_DEC_A   = 4'b1111;
   localparam op_t OP_ADD_AB  = 4'b1001;
   localparam op_t OP_ONES    = 4'b0011;
   localparam op_t OP_CONST1  = 4'b1100;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // Sub-class ops use an active-high borrow chain; everything else uses active-low carry.
   function automatic logic is_sub_op(input op_t op);
      return (op == OP_SUB_AB) || (op == OP_SUB_ANB) ||
             (op == OP_SUB_AAB) || (op == OP_DEC_A);
   endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU cell; time-multiplexed over the operand slices by the top.
module alu_slice
   import alu_pkg::*;
#(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  op_t              op,
   input  logic             mode,
   input  logic             cin,
   input  logic             first,
   output logic [SLICE-1:0] y,
   output logic             cout
);

   logic             w_sub;
   logic [SLICE-1:0] w_x;
   logic [SLICE-1:0] w_y;
   logic [SLICE:0]   w_sum;

   always_comb begin
      w_sub = is_sub_op(op);
      w_x   = '0;
      w_y   = '0;
      w_sum = '0;
      y     = '0;
      cout  = 1'b0;
      if (mode) begin
         case (op)
            4'b0000: y = ~a;
            4'b0001: y = ~(a | b);
            4'b0010: y = ~a & b;
            4'b0011: y = '0;
            4'b0100: y = ~(a & b);
            4'b0101: y = ~b;
            4'b0110: y = a ^ b;
            4'b0111: y = a & ~b;
            4'b1000: y = ~a | b;
            4'b1001: y = ~(a ^ b);
            4'b1010: y = b;
            4'b1011: y = a & b;
            4'b1100: y = first ? SLICE'(1) : '0;
            4'b1101: y = a | ~b;
            4'b1110: y = a | b;
            default: y = a;
         endcase
         cout = ~w_sub;
      end else if (w_sub) begin
         case (op)
            4'b0110: begin w_x = a; w_y = b; end
            4'b0111: w_x = a & ~b;
            4'b1011: w_x = a & b;
            default: w_x = a;
         endcase
         w_sum = {1'b0, w_x} - {1'b0, w_y} - {{SLICE{1'b0}}, cin};
         y     = w_sum[SLICE-1:0];
         cout  = w_sum[SLICE];
      end else begin
         case (op)
            4'b0000: w_x = a;
            4'b0001: w_x = a | b;
            4'b0010: w_x = a | ~b;
            4'b0011: w_x = '1;
            4'b0100: begin w_x = a;      w_y = a & ~b; end
            4'b0101: begin w_x = a | b;  w_y = a & ~b; end
            4'b1000: begin w_x = a;      w_y = a & b;  end
            4'b1001: begin w_x = a;      w_y = b;      end
            4'b1010: begin w_x = a | ~b; w_y = a & b;  end
            4'b1100: begin w_x = a;      w_y = a;      end
            4'b1101: begin w_x = a | b;  w_y = a;      end
            4'b1110: begin w_x = a | ~b; w_y = a;      end
            default: w_x = '0;
         endcase
         w_sum = {1'b0, w_x} + {1'b0, w_y} + {{SLICE{1'b0}}, ~cin};
         y     = w_sum[SLICE-1:0];
         cout  = ~w_sum[SLICE];
      end
   end

endmodule

// File: rtl/alu_slice_seq.sv
// Multi-cycle WIDTH-bit ALU: one SLICE-bit slice per clock, LSB slice first, with
// valid/ready on both sides and registered carry/zero/sign flags.
module alu_slice_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   input  logic             mode,
   input  logic             cf_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cf_out,
   output logic             zf,
   output logic             nf
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   if ((WIDTH % SLICE) != 0 || NSLICE < 1) begin : g_width_check
      $error("alu_slice_seq: WIDTH must be a non-zero multiple of SLICE");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   op_t              r_op;
   logic             r_mode;
   logic             r_carry;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_result;
   logic             r_cf;
   logic             r_zf;
   logic             r_nf;

   logic [SLICE-1:0] w_a_sl;
   logic [SLICE-1:0] w_b_sl;
   logic [SLICE-1:0] w_y;
   logic             w_cout;
   logic [WIDTH-1:0] w_next;

   // Slice select and result merge; w_next lets flags see the completed word on DONE entry.
   always_comb begin
      w_a_sl = '0;
      w_b_sl = '0;
      w_next = r_result;
      for (int unsigned k = 0; k < NSLICE; k++) begin
         if (r_idx == IW'(k)) begin
            w_a_sl                   = r_a[k*SLICE +: SLICE];
            w_b_sl                   = r_b[k*SLICE +: SLICE];
            w_next[k*SLICE +: SLICE] = w_y;
         end
      end
   end

   alu_slice #(.SLICE(SLICE)) u_slice (
      .a     (w_a_sl),
      .b     (w_b_sl),
      .op    (r_op),
      .mode  (r_mode),
      .cin   (r_carry),
      .first (r_idx == '0),
      .y     (w_y),
      .cout  (w_cout)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_mode   <= 1'b0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_result <= '0;
         r_cf     <= 1'b0;
         r_zf     <= 1'b0;
         r_nf     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_a      <= a;
               r_b      <= b;
               r_op     <= op;
               r_mode   <= mode;
               r_carry  <= cf_in;
               r_idx    <= '0;
               r_result <= '0;
               r_state  <= BUSY;
            end
            BUSY: begin
               r_result <= w_next;
               r_carry  <= w_cout;
               if (r_idx == IW'(NSLICE - 1)) begin
                  r_idx   <= '0;
                  r_cf    <= w_cout;
                  r_zf    <= (w_next == '0);
                  r_nf    <= w_next[WIDTH-1];
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
            DONE: if (out_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign result    = r_result;
   assign cf_out    = r_cf;
   assign zf        = r_zf;
   assign nf        = r_nf;

endmodule

// File: tb/tb_alu_slice_seq.sv
// Directed bench for alu_slice_seq at WIDTH=16, SLICE=8 with hand-computed expectations.
module tb_alu_slice_seq;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [3:0]  op = '0;
   logic        mode = 1'b0;
   logic        cf_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result;
   logic        cf_out;
   logic        zf;
   logic        nf;

   int checks = 0;
   int failures = 0;

   alu_slice_seq #(.WIDTH(16), .SLICE(8)) dut (
      .clk       (clk),
      .arst      (arst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .mode      (mode),
      .cf_in     (cf_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cf_out    (cf_out),
      .zf        (zf),
      .nf        (nf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic accept(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] iop,
                         input logic im, input logic icf, input string tag);
      @(negedge clk);
      a = ia; b = ib; op = iop; mode = im; cf_in = icf; in_valid = 1'b1;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] iop,
                        input logic im, input logic icf, input logic [15:0] er,
                        input logic ecf, input logic ezf, input logic enf, input string tag);
      int lat;
      accept(ia, ib, iop, im, icf, tag);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'd2);
      chk({tag, ".result"}, 32'(result), 32'(er));
      chk({tag, ".cf_out"}, 32'(cf_out), 32'(ecf));
      chk({tag, ".zf"}, 32'(zf), 32'(ezf));
      chk({tag, ".nf"}, 32'(nf), 32'(enf));
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk({tag, ".ready_after"}, 32'({in_ready, out_valid}), 32'b10);
   endtask

   initial begin
      #3;
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.result", 32'(result), 32'd0);
      chk("reset.flags", 32'({cf_out, zf, nf}), 32'd0);
      @(negedge clk);
      arst = 1'b0;

      do_op(16'h12FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h1300, 1'b1, 1'b0, 1'b0, "add_chain");
      do_op(16'h0000, 16'h0001, 4'b0110, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, "sub_borrow");
      do_op(16'h0100, 16'h0001, 4'b0110, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0, "sub_chain");
      do_op(16'h5555, 16'hAAAA, 4'b0011, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, "wrap_c0");
      do_op(16'h5555, 16'hAAAA, 4'b0011, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, "wrap_c1");
      do_op(16'hF0F0, 16'hFFFF, 4'b0110, 1'b1, 1'b0, 16'h0F0F, 1'b0, 1'b0, 1'b0, "logic_xor");
      do_op(16'hF0F0, 16'hFFFF, 4'b1100, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, "logic_one");
      do_op(16'hF0F0, 16'hFFFF, 4'b0011, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, "logic_zero");
      do_op(16'h0F00, 16'h00F0, 4'b0001, 1'b1, 1'b1, 16'hF00F, 1'b1, 1'b0, 1'b1, "logic_nor");
      do_op(16'h0000, 16'h1234, 4'b1111, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, "dec_a");
      do_op(16'h8080, 16'h0000, 4'b1100, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, "a_plus_a");
      do_op(16'h00F0, 16'h0030, 4'b0111, 1'b0, 1'b1, 16'h00BF, 1'b0, 1'b0, 1'b0, "andn_sub");
      do_op(16'h00FF, 16'h000F, 4'b0100, 1'b0, 1'b0, 16'h01F0, 1'b1, 1'b0, 1'b0, "a_plus_andn");

      // Backpressure: result holds while new operands are presented and ignored.
      do_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1, 16'h2345, 1'b1, 1'b0, 1'b0, "bp_warmup");
      accept(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1, "bp");
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         a = 16'hFFFF; b = 16'hFFFF; op = 4'b0011; mode = 1'b1; in_valid = 1'b1;
         @(posedge clk);
         #1;
         chk("bp.out_valid", 32'(out_valid), 32'd1);
         chk("bp.in_ready", 32'(in_ready), 32'd0);
         chk("bp.result", 32'(result), 32'h2345);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("bp.release_in_ready", 32'(in_ready), 32'd1);
      chk("bp.release_result", 32'(result), 32'h2345);

      // Asynchronous reset while BUSY discards the operation immediately.
      accept(16'h0101, 16'h0101, 4'b1001, 1'b0, 1'b1, "rst_busy");
      @(posedge clk);
      #1 arst = 1'b1;
      #1;
      chk("rst_busy.out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy.result", 32'(result), 32'd0);
      chk("rst_busy.in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      arst = 1'b0;
      do_op(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, "post_rst_add");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
